edge_event_arb: RTL and testbench
=================================

EDGE_EVENT_ARB -- requirements
Module: edge_event_arb

Interface
REQ-001 Parameter NCH, default 4, SHALL set the number of monitored input channels (2..16).
REQ-002 Parameter CHW, default 2, SHALL set the channel-index width; CHW SHALL equal clog2(NCH).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 d  input  NCH  SHALL carry the level inputs, one per channel, already synchronous to clk unless the synchronizer option is compiled in.
REQ-006 mode_wr  input  1  SHALL strobe a per-channel mode write for one cycle.
REQ-007 mode_ch  input  CHW  SHALL select the channel written by mode_wr.
REQ-008 mode_val  input  2  SHALL carry the mode: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 evt_valid  output  1  SHALL flag a valid event on evt_ch/evt_kind.
REQ-010 evt_ready  input  1  SHALL accept the event when high together with evt_valid.
REQ-011 evt_ch  output  CHW  SHALL give the channel of the presented event.
REQ-012 evt_kind  output  1  SHALL be 1 for a rising edge and 0 for a falling edge.
REQ-013 pend  output  NCH  SHALL show the per-channel pending flags.
REQ-014 ovf  output  NCH  SHALL show the sticky per-channel overflow flags.
REQ-015 ovf_clr  input  1  SHALL clear all ovf bits for one cycle.

Function
REQ-016 Each channel SHALL keep a previous-level register d_q and SHALL detect an edge when d differs from d_q, qualified by the channel mode.
REQ-017 A qualified edge SHALL set pend[i] and SHALL record its kind on the same clock edge at which the new level is first sampled.
REQ-018 An edge arriving while pend[i] is already set and not being granted in that cycle SHALL set ovf[i], SHALL overwrite the kind with the newest edge, and SHALL leave pend[i] set.
REQ-019 When a grant and a new edge hit the same channel in the same cycle, the set SHALL win, pend[i] SHALL stay 1, and ovf[i] SHALL NOT be set.
REQ-020 The output register SHALL have states IDLE (evt_valid=0) and HOLD (evt_valid=1).
REQ-021 The output SHALL load from the arbiter when in IDLE, or in HOLD with evt_ready=1.
REQ-022 A load SHALL clear the granted pend bit, and the event SHALL appear at the next clock edge, giving 1 cycle of latency from pend to evt_valid.
REQ-023 In HOLD with evt_ready=0, evt_valid, evt_ch and evt_kind SHALL remain stable.
REQ-024 With evt_ready held high, back-to-back events SHALL issue at one per cycle.
REQ-025 Arbitration SHALL be round-robin: the search SHALL start at the channel after the last granted one, wrapping from NCH-1 to 0, and channel 0 SHALL have priority after reset.
REQ-026 Writing mode 00 SHALL clear pend[i] in the same cycle; a concurrent edge on that channel SHALL be ignored.
REQ-027 Out-of-range mode_ch values (>= NCH) SHALL be ignored.
REQ-028 If ovf_clr and a new overflow occur in the same cycle, the new overflow SHALL win.

Reset
REQ-029 rst SHALL clear pend, ovf, evt_valid, evt_ch and evt_kind to 0, set every mode to 00, and point round-robin at channel 0.
REQ-030 On the first cycle after rst deasserts, d_q SHALL load d without generating edges.
REQ-031 Reset asserted during HOLD SHALL drop evt_valid at that edge and discard the event.

Configuration
REQ-032 With EDGE_ARB_SYNC_EN defined, each d bit SHALL pass through a two-flop synchronizer before d_q, adding 2 cycles of edge latency; the synchronizer flops SHALL reset to 0.
REQ-033 Without EDGE_ARB_SYNC_EN, d SHALL feed the edge detector directly, with no added latency.

Verification
REQ-034 Ch0 mode 01, evt_ready=1; d[0] goes 0->1 -> pend[0] is 1 at the next clock, then evt_valid=1, evt_ch=0, evt_kind=1 one cycle later, for one cycle.
REQ-035 Ch0 mode 10; d[0] goes 1->0 then 0->1 -> exactly one event, evt_kind=0; the rising edge is ignored.
REQ-036 All channels mode 11, evt_ready=1; d goes 0000->1111 in one cycle -> events on ch 0,1,2,3 on consecutive cycles, then the next edge is served starting at ch0 after ch3 wrap.
REQ-037 evt_ready=0 with ch1 in HOLD; two edges arrive on ch2 -> ovf[2]=1, the ch1 outputs stay stable, and after evt_ready=1 a ch2 event is issued with the latest kind.
REQ-038 rst pulsed during HOLD, with d=1111 held -> evt_valid=0, pend=0, and no events issued after rst deasserts.
REQ-039 EDGE_ARB_SYNC_EN defined; the REQ-034 stimulus -> evt_valid asserts 2 cycles later than without the macro.

Source files
------------

// File: rtl/edge_event_arb.sv
// Purpose : per-channel edge detector feeding a round-robin arbiter and a one-deep event output register.
// Latency : 1 cycle from pend set to evt_valid; +2 cycles of edge latency when EDGE_ARB_SYNC_EN is defined.
// Backpr. : valid/ready. The output holds stable while evt_ready=0, and repeat edges on a waiting channel set ovf.
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   d[NCH]                 level inputs, one per channel
//   mode_wr/mode_ch/mode_val  per-channel mode write (00 off, 01 rise, 10 fall, 11 both)
//   evt_valid/evt_ready    event handshake; evt_ch/evt_kind carry channel and kind (1 = rising)
//   pend[NCH], ovf[NCH]    pending flags and sticky overflow flags; ovf_clr clears ovf
//
// Option macro: EDGE_ARB_SYNC_EN inserts a two-flop synchronizer on every d bit.
module edge_event_arb #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] d,
    input  logic           mode_wr,
    input  logic [CHW-1:0] mode_ch,
    input  logic [1:0]     mode_val,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [CHW-1:0] evt_ch,
    output logic           evt_kind,
    output logic [NCH-1:0] pend,
    output logic [NCH-1:0] ovf,
    input  logic           ovf_clr
);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t               state_q, state_d;
    logic [NCH-1:0]       d_s;
    logic [NCH-1:0]       d_q;
    logic                 primed_q;
    logic [NCH-1:0][1:0]  mode_q;
    logic [NCH-1:0]       pend_q, ovf_q, kind_q;
    logic [NCH-1:0]       mode_clr, edge_det, gnt_oh;
    logic [NCH-1:0]       pend_d, ovf_d, kind_d;
    logic [CHW-1:0]       ptr_q;
    logic [CHW-1:0]       gnt_ch;
    logic [CHW-1:0]       arb_idx;
    logic                 gnt_vld;
    logic                 load;
    logic                 fire;
    int                   arb_sum;

`ifdef EDGE_ARB_SYNC_EN
    logic [NCH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
        end
    end

    assign d_s = sync2_q;
`else
    assign d_s = d;
`endif

    // Edge qualification. A mode-00 write kills any edge on that channel in the
    // same cycle; mode_ch values >= NCH never match a channel and are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign mode_clr[i] = mode_wr && (mode_val == 2'b00) && (mode_ch == CHW'(i));
        assign edge_det[i] = primed_q && (d_s[i] != d_q[i]) && !mode_clr[i] &&
                             (d_s[i] ? mode_q[i][0] : mode_q[i][1]);
        assign gnt_oh[i]   = fire && (gnt_ch == CHW'(i));
    end

    // Round-robin search starting at ptr_q (the channel after the last grant).
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        arb_idx = '0;
        arb_sum = 0;
        for (int k = 0; k < NCH; k++) begin
            arb_sum = int'(ptr_q) + k;
            if (arb_sum >= NCH) begin
                arb_sum = arb_sum - NCH;
            end
            arb_idx = CHW'(arb_sum);
            if (!gnt_vld && pend_q[arb_idx]) begin
                gnt_vld = 1'b1;
                gnt_ch  = arb_idx;
            end
        end
    end

    // Output FSM: load whenever the register is empty or being drained.
    always_comb begin
        state_d = state_q;
        load    = (state_q == S_IDLE) || evt_ready;
        fire    = load && gnt_vld;
        if (load) begin
            state_d = gnt_vld ? S_HOLD : S_IDLE;
        end
    end

    // A new edge beats a same-cycle grant; overflow only when the old pending
    // event is still waiting. A new overflow beats ovf_clr.
    assign pend_d = ((pend_q & ~gnt_oh) | edge_det) & ~mode_clr;
    assign ovf_d  = (ovf_clr ? '0 : ovf_q) | (edge_det & pend_q & ~gnt_oh);
    assign kind_d = (kind_q & ~edge_det) | (d_s & edge_det);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            evt_ch   <= '0;
            evt_kind <= 1'b0;
            ptr_q    <= '0;
            pend_q   <= '0;
            ovf_q    <= '0;
            kind_q   <= '0;
            mode_q   <= '0;
            d_q      <= '0;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            kind_q   <= kind_d;
            d_q      <= d_s;
            primed_q <= 1'b1;
            if (fire) begin
                evt_ch   <= gnt_ch;
                evt_kind <= kind_q[gnt_ch];
                ptr_q    <= (gnt_ch == CHW'(NCH - 1)) ? '0 : gnt_ch + 1'b1;
            end
            if (mode_wr && (int'(mode_ch) < NCH)) begin
                mode_q[mode_ch] <= mode_val;
            end
        end
    end

    assign evt_valid = (state_q == S_HOLD);
    assign pend      = pend_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_arb.sv
module tb_edge_event_arb;

    localparam int NCH = 4;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] d = '0;
    logic           mode_wr = 1'b0;
    logic [CHW-1:0] mode_ch = '0;
    logic [1:0]     mode_val = '0;
    logic           evt_ready = 1'b0;
    logic           ovf_clr = 1'b0;
    logic           evt_valid;
    logic [CHW-1:0] evt_ch;
    logic           evt_kind;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    edge_event_arb #(.NCH(NCH), .CHW(CHW)) dut (
        .clk(clk), .rst(rst), .d(d),
        .mode_wr(mode_wr), .mode_ch(mode_ch), .mode_val(mode_val),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_ch(evt_ch), .evt_kind(evt_kind),
        .pend(pend), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain per-channel arrays updated from the rules each clock.
    int m_mode[NCH];
    bit m_prev[NCH], m_pend[NCH], m_kind[NCH], m_ovf[NCH];
    bit m_primed;
    int m_ptr;
    bit m_valid;
    int m_ch;
    bit m_evkind;

    task automatic model_step();
        bit load, clr, lvl, e, rise_ok, fall_ok;
        int g;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_mode[i] = 0; m_pend[i] = 0; m_kind[i] = 0; m_ovf[i] = 0; m_prev[i] = 0;
            end
            m_primed = 0; m_ptr = 0; m_valid = 0; m_ch = 0; m_evkind = 0;
            return;
        end
        load = !m_valid || evt_ready;
        g = -1;
        if (load) begin
            for (int k = 0; k < NCH; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
            end
            if (g >= 0) begin
                m_valid = 1; m_ch = g; m_evkind = m_kind[g]; m_ptr = (g + 1) % NCH;
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            clr = mode_wr && (int'(mode_ch) == i) && (mode_val == 2'b00);
            lvl = d[i];
            rise_ok = (m_mode[i] == 1) || (m_mode[i] == 3);
            fall_ok = (m_mode[i] >= 2);
            e = m_primed && (lvl != m_prev[i]) && !clr && (lvl ? rise_ok : fall_ok);
            if (e && m_pend[i] && g != i) m_ovf[i] = 1;
            else if (ovf_clr) m_ovf[i] = 0;
            if (clr) m_pend[i] = 0;
            else if (e) m_pend[i] = 1;
            else if (g == i) m_pend[i] = 0;
            if (e) m_kind[i] = lvl;
            m_prev[i] = lvl;
        end
        if (mode_wr && int'(mode_ch) < NCH) m_mode[mode_ch] = int'(mode_val);
        m_primed = 1;
    endtask

    always @(posedge clk) model_step();

    function automatic logic [NCH-1:0] vec(input bit a[NCH]);
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check("m_valid", evt_valid, m_valid);
        if (m_valid) begin
            check("m_ch", evt_ch, m_ch);
            check("m_kind", evt_kind, m_evkind);
        end
        check("m_pend", pend, vec(m_pend));
        check("m_ovf", ovf, vec(m_ovf));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", evt_valid, 0);
        check("rst_pend", pend, 0);
        check("rst_ovf", ovf, 0);
        check("rst_ch", evt_ch, 0);
        check("rst_kind", evt_kind, 0);
        rst = 1'b0;
        tick();
    endtask

    task automatic set_mode(input int ch, input logic [1:0] v);
        mode_wr = 1'b1; mode_ch = CHW'(ch); mode_val = v;
        tick();
        mode_wr = 1'b0;
    endtask

    int n;
    bit last_kind;

    initial begin
        // Single rising edge: pend next clock, event one clock later, for one cycle.
        d = '0; evt_ready = 1'b1;
        do_reset();
        set_mode(0, 2'b01);
        tick();
        d[0] = 1'b1;
        tick();
        check("r34_pend", pend, 4'b0001);
        check("r34_vld0", evt_valid, 0);
        tick();
        check("r34_vld", evt_valid, 1);
        check("r34_ch", evt_ch, 0);
        check("r34_kind", evt_kind, 1);
        tick();
        check("r34_vld_drop", evt_valid, 0);

        // Falling-only mode ignores the rising edge.
        d = '0;
        do_reset();
        set_mode(0, 2'b10);
        d[0] = 1'b1;
        tick();
        tick();
        d[0] = 1'b0;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (evt_valid) begin n++; last_kind = evt_kind; end
        end
        d[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (evt_valid) begin n++; last_kind = evt_kind; end
        end
        check("r35_count", n, 1);
        check("r35_kind", last_kind, 0);

        // All channels at once, then wrap back to ch0.
        d = '0;
        do_reset();
        for (int c = 0; c < NCH; c++) set_mode(c, 2'b11);
        tick();
        d = 4'hF;
        tick();
        check("r36_pend", pend, 4'hF);
        for (int c = 0; c < NCH; c++) begin
            tick();
            check("r36_vld", evt_valid, 1);
            check("r36_ch", evt_ch, c);
        end
        d = '0;
        tick();
        check("r36_gap", evt_valid, 0);
        tick();
        check("r36_wrap_ch", evt_ch, 0);
        check("r36_wrap_kind", evt_kind, 0);

        // Overflow while another channel is held.
        d = '0; evt_ready = 1'b0;
        do_reset();
        set_mode(1, 2'b11);
        set_mode(2, 2'b11);
        d[1] = 1'b1;
        tick();
        tick();
        check("r37_hold_ch", evt_ch, 1);
        d[2] = 1'b1;
        tick();
        d[2] = 1'b0;
        tick();
        check("r37_ovf", ovf, 4'b0100);
        check("r37_stable_vld", evt_valid, 1);
        check("r37_stable_ch", evt_ch, 1);
        check("r37_stable_kind", evt_kind, 1);
        evt_ready = 1'b1;
        tick();
        check("r37_ch2", evt_ch, 2);
        check("r37_kind", evt_kind, 0);

        // Reset during HOLD with inputs held high.
        d = '0; evt_ready = 1'b0;
        do_reset();
        for (int c = 0; c < NCH; c++) set_mode(c, 2'b11);
        d = 4'hF;
        tick();
        tick();
        check("r38_hold", evt_valid, 1);
        rst = 1'b1;
        tick();
        check("r38_vld", evt_valid, 0);
        check("r38_pend", pend, 0);
        rst = 1'b0;
        evt_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (evt_valid) n++;
        end
        check("r38_noevt", n, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            mode_wr   = ($urandom_range(0, 3) == 0);
            mode_ch   = CHW'($urandom_range(0, NCH - 1));
            mode_val  = 2'($urandom_range(0, 3));
            evt_ready = ($urandom_range(0, 9) < 7);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 3) == 0) d[i] = ~d[i];
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
